// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command-decoding single-port RAM behind an SPI slave.
// Decodes 10-bit command words from the slave and services write/read
// address and data commands. Each accepted read holds its byte on tx_data
// for a TX_HOLD-cycle tx_valid window so the slave can shift it onto MISO.
//
// Ports:
//   clk       in   1   clock, rising-edge
//   rst       in   1   asynchronous reset, active-high
//   rx_valid  in   1   rx_data carries a command word this cycle
//   rx_data   in   10  [9:8] command, [7:0] address/data payload
//   tx_data   out  8   captured read byte, stable across the tx_valid window
//   tx_valid  out  1   high for TX_HOLD consecutive cycles per accepted read
module spi_ram_ctrl #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned TX_HOLD   = 8,
    parameter int unsigned AUTO_INC  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [9:0] rx_data,
    output logic [7:0] tx_data,
    output logic       tx_valid
);

    localparam int unsigned CNT_W = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;
    localparam int unsigned AW1   = ADDR_SIZE + 1;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_TXING = 1'b1
    } state_t;

    state_t               state_q,    state_d;
    logic [ADDR_SIZE-1:0] wr_addr_q,  wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q,  rd_addr_d;
    logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [7:0]           tx_data_q,  tx_data_d;
    logic                 tx_valid_q, tx_valid_d;

    logic [7:0] mem [MEM_DEPTH];

    logic       mem_we_c;
    logic       wr_in_range_c;
    logic       rd_in_range_c;
    logic       rd_accept_c;
    logic [7:0] rd_byte_c;

    // Post-increment with wrap at the top of the populated address range.
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        if (AW1'(a) == AW1'(MEM_DEPTH - 1)) begin
            return '0;
        end
        return a + ADDR_SIZE'(1);
    endfunction

    // Addresses beyond MEM_DEPTH have no storage behind them.
    always_comb begin
        wr_in_range_c = (AW1'(wr_addr_q) < AW1'(MEM_DEPTH));
        rd_in_range_c = (AW1'(rd_addr_q) < AW1'(MEM_DEPTH));
        rd_byte_c     = rd_in_range_c ? mem[rd_addr_q] : 8'h00;
    end

    // Command decode and transmit-window state machine.
    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        hold_cnt_d  = hold_cnt_q;
        tx_data_d   = tx_data_q;
        mem_we_c    = 1'b0;
        rd_accept_c = 1'b0;

        if (rx_valid) begin
            unique case (rx_data[9:8])
                CMD_WR_ADDR: begin
                    wr_addr_d = rx_data[ADDR_SIZE-1:0];
                end
                CMD_WR_DATA: begin
                    mem_we_c = wr_in_range_c;
                    if (AUTO_INC != 0) begin
                        wr_addr_d = next_addr(wr_addr_q);
                    end
                end
                CMD_RD_ADDR: begin
                    rd_addr_d = rx_data[ADDR_SIZE-1:0];
                end
                CMD_RD_DATA: begin
                    // A read arriving mid-window is dropped without side effects.
                    if (state_q == ST_IDLE) begin
                        rd_accept_c = 1'b1;
                        tx_data_d   = rd_byte_c;
                        if (AUTO_INC != 0) begin
                            rd_addr_d = next_addr(rd_addr_q);
                        end
                    end
                end
                default: ;
            endcase
        end

        unique case (state_q)
            ST_IDLE: begin
                if (rd_accept_c) begin
                    state_d    = ST_TXING;
                    hold_cnt_d = CNT_W'(TX_HOLD - 1);
                end
            end
            ST_TXING: begin
                if (hold_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tx_valid_d = (state_d == ST_TXING);
    end

    // Control state; memory is deliberately left out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            hold_cnt_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            hold_cnt_q <= hold_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    // Storage array, written at the command edge.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[wr_addr_q] <= rx_data[7:0];
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: directed-vector bench for spi_ram_ctrl.
// Three instances (default, AUTO_INC with full depth, shallow 200-word RAM)
// see identical command streams; a per-instance behavioural model predicts
// tx_valid/tx_data every cycle and literal checks pin key results.
module tb_spi_ram_ctrl;

    localparam int TXH = 8;
    localparam int NI  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [9:0] rx_data;
    logic [7:0] txd [NI];
    logic       txv [NI];

    always #5 clk = ~clk;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .TX_HOLD(TXH), .AUTO_INC(0)) u0 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_data(txd[0]), .tx_valid(txv[0]));
    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .TX_HOLD(TXH), .AUTO_INC(1)) u1 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_data(txd[1]), .tx_valid(txv[1]));
    spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_SIZE(8), .TX_HOLD(TXH), .AUTO_INC(0)) u2 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_data(txd[2]), .tx_valid(txv[2]));

    int n_vec  = 0;
    int n_fail = 0;

    // Model state: memory image with known-flags, address pointers, and the
    // cycle index at which the current read window began.
    int         dep  [NI] = '{256, 256, 200};
    bit         ainc [NI] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] m_mem [NI][256];
    bit         m_kn  [NI][256];
    int         m_wa [NI];
    int         m_ra [NI];
    int         m_ws [NI];
    logic [7:0] m_tx [NI];
    bit         m_txk[NI];
    int         cyc = 0;
    bit         run = 1'b0;

    function automatic bit in_win(int i, int c);
        return (c >= m_ws[i]) && (c < m_ws[i] + TXH);
    endfunction

    function automatic int bump(int i, int a);
        return (a == dep[i] - 1) ? 0 : (a + 1) % 256;
    endfunction

    task automatic chk(string nm, int i, logic [7:0] act, logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d: got %h expected %h at t=%0t", nm, i, act, exp, $time);
        end
    endtask

    // Behavioural model, advanced on every clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NI; i++) begin
                m_wa[i] = 0;
                m_ra[i] = 0;
                m_ws[i] = -100;
            end
        end else begin
            cyc = cyc + 1;
            if (rx_valid) begin
                for (int i = 0; i < NI; i++) begin
                    case (rx_data[9:8])
                        2'b00: m_wa[i] = int'(rx_data[7:0]);
                        2'b01: begin
                            if (m_wa[i] < dep[i]) begin
                                m_mem[i][m_wa[i]] = rx_data[7:0];
                                m_kn[i][m_wa[i]]  = 1'b1;
                            end
                            if (ainc[i]) m_wa[i] = bump(i, m_wa[i]);
                        end
                        2'b10: m_ra[i] = int'(rx_data[7:0]);
                        default: begin
                            // accepted only if the previous cycle showed no window
                            if (!in_win(i, cyc - 1)) begin
                                m_ws[i] = cyc;
                                if (m_ra[i] < dep[i]) begin
                                    m_tx[i]  = m_mem[i][m_ra[i]];
                                    m_txk[i] = m_kn[i][m_ra[i]];
                                end else begin
                                    m_tx[i]  = 8'h00;
                                    m_txk[i] = 1'b1;
                                end
                                if (ainc[i]) m_ra[i] = bump(i, m_ra[i]);
                            end
                        end
                    endcase
                end
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (run && !rst) begin
            for (int i = 0; i < NI; i++) begin
                chk("tx_valid", i, 8'(txv[i]), 8'(in_win(i, cyc)));
                if (in_win(i, cyc) && m_txk[i]) chk("tx_data", i, txd[i], m_tx[i]);
            end
        end
    end

    task automatic send(input logic [9:0] w);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = w;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 10'($urandom);
    endtask

    // Wait for instance i's window to close; a stuck window is a failure.
    task automatic wait_low(int i);
        int k = 0;
        while (txv[i] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("window_close", i, 8'(txv[i]), 8'h00);
    endtask

    // Measure the remaining window length of instance i (called on its first cycle).
    task automatic win_len(int i, int exp);
        int k = 0;
        while (txv[i] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("window_len", i, 8'(k), 8'(exp));
    endtask

    initial begin
        for (int i = 0; i < NI; i++) m_ws[i] = -100;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) chk("reset_valid", i, 8'(txv[i]), 8'h00);
        chk("reset_data", 0, txd[0], 8'h00);
        rst = 1'b0;
        run = 1'b1;
        repeat (2) @(negedge clk);

        // Basic write then read of A5 at address 5.
        send(10'h005); send(10'h1A5); send(10'h205); send(10'h300);
        chk("rd_a5", 0, txd[0], 8'hA5);
        chk("rd_a5_valid", 0, 8'(txv[0]), 8'h01);
        win_len(0, TXH);
        repeat (2) @(negedge clk);

        // Mid-window read ignored; write to the address in flight leaves tx_data intact.
        send(10'h300);
        send(10'h300);
        send(10'h1FF);
        chk("captured_a5", 0, txd[0], 8'hA5);
        wait_low(0);
        send(10'h300);
        chk("rd_after_wr", 0, txd[0], 8'hFF);
        wait_low(0);
        wait_low(1);

        // Auto-increment wrap FF -> 00.
        send(10'h0FF); send(10'h111); send(10'h122);
        send(10'h2FF); send(10'h300);
        chk("wrap_rd_ff", 1, txd[1], 8'h11);
        chk("oob_rd_ff", 2, txd[2], 8'h00);
        wait_low(1);
        send(10'h300);
        chk("wrap_rd_00", 1, txd[1], 8'h22);
        wait_low(1);

        // Out-of-range write dropped and read returns zero with a full window.
        send(10'h0C8); send(10'h177); send(10'h2C8); send(10'h300);
        chk("oob_rd_c8", 2, txd[2], 8'h00);
        chk("rd_c8", 0, txd[0], 8'h77);
        win_len(2, TXH);
        repeat (2) @(negedge clk);

        // Back-to-back reads at the earliest acceptable cycle: one low cycle between.
        send(10'h300);
        repeat (7) @(negedge clk);
        chk("b2b_last_high", 0, 8'(txv[0]), 8'h01);
        @(negedge clk);
        chk("b2b_gap_low", 0, 8'(txv[0]), 8'h00);
        rx_valid = 1'b1;
        rx_data  = 10'h300;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("b2b_second_high", 0, 8'(txv[0]), 8'h01);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a window.
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) chk("async_rst_valid", i, 8'(txv[i]), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(10'h13C);
        send(10'h300);
        for (int i = 0; i < NI; i++) chk("post_rst_rd0", i, txd[i], 8'h3C);
        wait_low(0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
